// File: rtl/cm_pkg.sv
// Shared definitions for the CM window counter: boundary-mode encodings and default axis widths.
package cm_pkg;

  typedef enum logic {
    CM_WIN_STRICT    = 1'b0,
    CM_WIN_INCLUSIVE = 1'b1
  } cm_win_mode_e;

  localparam int CM_H_WIDTH_DEF = 11;
  localparam int CM_V_WIDTH_DEF = 10;

endpackage

// File: rtl/cm_axis_window.sv
// One axis of the window counter: saturating position counter, porch shadow and in-window compare.
// With CM_WINDOW_COUNTER_ERR_EN defined, also reports saturation and degenerate porch loads.
module cm_axis_window
  import cm_pkg::*;
#(
  parameter int           WIDTH = CM_H_WIDTH_DEF,
  parameter cm_win_mode_e MODE  = CM_WIN_STRICT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] back_porch,
  input  logic [WIDTH-1:0] front_porch,
`ifdef CM_WINDOW_COUNTER_ERR_EN
  output logic             sat,
  output logic             degen_load,
`endif
  output logic             in_win
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] back_q, back_d;
  logic [WIDTH-1:0] front_q, front_d;
  logic [WIDTH-1:0] back_eff, front_eff;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The load cycle compares against the incoming porches, not the stale shadow.
  always_comb begin
    back_d    = load ? back_porch  : back_q;
    front_d   = load ? front_porch : front_q;
    back_eff  = back_d;
    front_eff = front_d;
    if (MODE == CM_WIN_INCLUSIVE) begin
      in_win = (cnt_q >= back_eff) && (cnt_q <= front_eff);
    end else begin
      in_win = (cnt_q > back_eff) && (cnt_q < front_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      back_q  <= '0;
      front_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      front_q <= front_d;
    end
  end

`ifdef CM_WINDOW_COUNTER_ERR_EN
  logic [WIDTH:0] back_p1;

  // Widened by one bit so a back porch of all-ones still reads as degenerate.
  always_comb begin
    back_p1 = {1'b0, back_porch} + {{WIDTH{1'b0}}, 1'b1};
    sat     = inc && !clr && (cnt_q == CNT_MAX);
    if (MODE == CM_WIN_INCLUSIVE) begin
      degen_load = load && (front_porch < back_porch);
    end else begin
      degen_load = load && ({1'b0, front_porch} <= back_p1);
    end
  end
`endif

endmodule

// File: rtl/cm_window_counter.sv
// 2-D active-window position counter: qualifies col/row inside the programmed porches and pulses line/frame ends.
// Optional sticky err output is built when CM_WINDOW_COUNTER_ERR_EN is defined.
module cm_window_counter
  import cm_pkg::*;
#(
  parameter int H_WIDTH   = CM_H_WIDTH_DEF,
  parameter int V_WIDTH   = CM_V_WIDTH_DEF,
  parameter int INCLUSIVE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_WIDTH-1:0] h_back_porch,
  input  logic [H_WIDTH-1:0] h_front_porch,
  input  logic [V_WIDTH-1:0] v_back_porch,
  input  logic [V_WIDTH-1:0] v_front_porch,
  input  logic               hsync,
  input  logic               vsync,
`ifdef CM_WINDOW_COUNTER_ERR_EN
  output logic               err,
`endif
  output logic               valid,
  output logic [H_WIDTH-1:0] col,
  output logic [V_WIDTH-1:0] row,
  output logic               line_end,
  output logic               frame_end
);

  localparam cm_win_mode_e MODE = (INCLUSIVE != 0) ? CM_WIN_INCLUSIVE : CM_WIN_STRICT;

  logic               hsync_prev_q, hsync_prev_d;
  logic               vsync_prev_q, vsync_prev_d;
  logic               valid_q, valid_d;
  logic [H_WIDTH-1:0] col_q, col_d;
  logic [V_WIDTH-1:0] row_q, row_d;
  logic               line_end_q, line_end_d;
  logic               frame_end_q, frame_end_d;

  logic h_rise, v_rise, line_done;
  logic h_clr, v_clr, v_inc;
  logic h_in, v_in, valid_nxt;

  assign h_rise    = hsync & ~hsync_prev_q;
  assign v_rise    = vsync & ~vsync_prev_q;
  assign line_done = hsync_prev_q & ~hsync;
  assign h_clr     = ~hsync;
  assign v_clr     = ~vsync;
  assign v_inc     = vsync & line_done;

`ifdef CM_WINDOW_COUNTER_ERR_EN
  logic h_sat, v_sat, h_degen, v_degen;
  logic err_q, err_d;
`endif

  cm_axis_window #(
    .WIDTH (H_WIDTH),
    .MODE  (MODE)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .clr         (h_clr),
    .inc         (hsync),
    .load        (h_rise),
    .back_porch  (h_back_porch),
    .front_porch (h_front_porch),
`ifdef CM_WINDOW_COUNTER_ERR_EN
    .sat         (h_sat),
    .degen_load  (h_degen),
`endif
    .in_win      (h_in)
  );

  cm_axis_window #(
    .WIDTH (V_WIDTH),
    .MODE  (MODE)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .clr         (v_clr),
    .inc         (v_inc),
    .load        (v_rise),
    .back_porch  (v_back_porch),
    .front_porch (v_front_porch),
`ifdef CM_WINDOW_COUNTER_ERR_EN
    .sat         (v_sat),
    .degen_load  (v_degen),
`endif
    .in_win      (v_in)
  );

  // A line that ends on the same edge vsync drops still counts as a line of this frame.
  always_comb begin
    valid_nxt    = hsync & vsync & h_in & v_in;
    hsync_prev_d = hsync;
    vsync_prev_d = vsync;
    valid_d      = valid_nxt;
    col_d        = '0;
    if (valid_nxt && valid_q) begin
      col_d = col_q + 1'b1;
    end
    row_d = row_q;
    if (!vsync) begin
      row_d = '0;
    end else if (line_done && v_in) begin
      row_d = row_q + 1'b1;
    end
    line_end_d  = line_done & vsync_prev_q;
    frame_end_d = vsync_prev_q & ~vsync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      valid_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      hsync_prev_q <= hsync_prev_d;
      vsync_prev_q <= vsync_prev_d;
      valid_q      <= valid_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_end_q   <= line_end_d;
      frame_end_q  <= frame_end_d;
    end
  end

`ifdef CM_WINDOW_COUNTER_ERR_EN
  always_comb begin
    err_d = err_q | h_sat | v_sat | h_degen | v_degen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign valid     = valid_q;
  assign col       = col_q;
  assign row       = row_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_cm_window_counter.sv
// Scoreboard bench for cm_window_counter: strict and inclusive instances share one stimulus stream.
module tb_cm_window_counter;

  localparam int HW = 11;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [HW-1:0] h_back, h_front;
  logic [VW-1:0] v_back, v_front;
  logic          hsync, vsync;

  logic          valid_s, valid_i;
  logic [HW-1:0] col_s, col_i;
  logic [VW-1:0] row_s, row_i;
  logic          line_end_s, line_end_i, frame_end_s, frame_end_i;
`ifdef CM_WINDOW_COUNTER_ERR_EN
  logic          err_s, err_i;
`endif

  always #5 clk = ~clk;

  cm_window_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .INCLUSIVE(0)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .h_back_porch  (h_back),
    .h_front_porch (h_front),
    .v_back_porch  (v_back),
    .v_front_porch (v_front),
    .hsync         (hsync),
    .vsync         (vsync),
`ifdef CM_WINDOW_COUNTER_ERR_EN
    .err           (err_s),
`endif
    .valid         (valid_s),
    .col           (col_s),
    .row           (row_s),
    .line_end      (line_end_s),
    .frame_end     (frame_end_s)
  );

  cm_window_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .INCLUSIVE(1)) dut_i (
    .clk           (clk),
    .rst           (rst),
    .h_back_porch  (h_back),
    .h_front_porch (h_front),
    .v_back_porch  (v_back),
    .v_front_porch (v_front),
    .hsync         (hsync),
    .vsync         (vsync),
`ifdef CM_WINDOW_COUNTER_ERR_EN
    .err           (err_i),
`endif
    .valid         (valid_i),
    .col           (col_i),
    .row           (row_i),
    .line_end      (line_end_i),
    .frame_end     (frame_end_i)
  );

  typedef struct {
    int col;
    int row;
  } pix_t;

  pix_t q_s[$];
  pix_t q_i[$];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int nv_s = 0, nv_i = 0;
  int nle_s = 0, nle_i = 0, nfe_s = 0, nfe_i = 0;
  int exp_le = 0, exp_fe = 0;

  int line_k, rows_s, rows_i, vb_m, vf_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pix_t p;
    if (chk_en) begin
      if (valid_s) begin
        nv_s++;
        if (q_s.size() == 0) begin
          check("unexpected valid strict", 32'd1, 32'd0);
        end else begin
          p = q_s.pop_front();
          check("col strict", 32'(col_s), p.col);
          check("row strict", 32'(row_s), p.row);
        end
      end
      if (valid_i) begin
        nv_i++;
        if (q_i.size() == 0) begin
          check("unexpected valid inclusive", 32'd1, 32'd0);
        end else begin
          p = q_i.pop_front();
          check("col inclusive", 32'(col_i), p.col);
          check("row inclusive", 32'(row_i), p.row);
        end
      end
      nle_s += int'(line_end_s);
      nle_i += int'(line_end_i);
      nfe_s += int'(frame_end_s);
      nfe_i += int'(frame_end_i);
    end
  end

  function automatic bit in_win(input int n, input int b, input int f, input bit incl);
    if (incl) return (b <= n) && (n <= f);
    return (b < n) && (n < f);
  endfunction

  task automatic model_frame_begin(input int vb, input int vf);
    line_k = 0;
    rows_s = 0;
    rows_i = 0;
    vb_m   = vb;
    vf_m   = vf;
  endtask

  // Expected pixels of one line: positions 0..L-1 inside both windows, col counted within the run.
  task automatic model_line(input int len, input int hb, input int hf);
    pix_t p;
    int   c;
    bit   vin;
    vin = in_win(line_k, vb_m, vf_m, 1'b0);
    c = 0;
    for (int n = 0; n < len; n++) begin
      if (vin && in_win(n, hb, hf, 1'b0)) begin
        p.col = c; p.row = rows_s; q_s.push_back(p); c++;
      end
    end
    if (vin) rows_s++;
    vin = in_win(line_k, vb_m, vf_m, 1'b1);
    c = 0;
    for (int n = 0; n < len; n++) begin
      if (vin && in_win(n, hb, hf, 1'b1)) begin
        p.col = c; p.row = rows_i; q_i.push_back(p); c++;
      end
    end
    if (vin) rows_i++;
    line_k++;
    exp_le++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int vb, input int vf, input int idle);
    v_back  = VW'(vb);
    v_front = VW'(vf);
    hsync   = 1'b0;
    vsync   = 1'b1;
    model_frame_begin(vb, vf);
    repeat (idle) tick();
  endtask

  task automatic run_line(input int len, input int hb, input int hf,
                          input int hb2, input int hf2, input int chg);
    model_line(len, hb, hf);
    h_back  = HW'(hb);
    h_front = HW'(hf);
    hsync   = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == chg && i > 0) begin
        h_back  = HW'(hb2);
        h_front = HW'(hf2);
      end
      tick();
    end
  endtask

  task automatic gap(input int g);
    hsync = 1'b0;
    repeat (g) tick();
  endtask

  task automatic end_frame(input int idle);
    hsync = 1'b0;
    vsync = 1'b0;
    exp_fe++;
    tick();
    repeat (idle) tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, " pending strict"}, q_s.size(), 32'd0);
    check({tag, " pending inclusive"}, q_i.size(), 32'd0);
    check({tag, " line_end strict"}, nle_s, exp_le);
    check({tag, " line_end inclusive"}, nle_i, exp_le);
    check({tag, " frame_end strict"}, nfe_s, exp_fe);
    check({tag, " frame_end inclusive"}, nfe_i, exp_fe);
    nv_s = 0; nv_i = 0; nle_s = 0; nle_i = 0; nfe_s = 0; nfe_i = 0;
    exp_le = 0; exp_fe = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vb, vf, nl, len, hb, hf, chg;
    rst = 1'b1; hsync = 1'b0; vsync = 1'b0;
    h_back = '0; h_front = '0; v_back = '0; v_front = '0;
    tick(); tick();
    check("reset valid s", 32'(valid_s), 32'd0);
    check("reset col s", 32'(col_s), 32'd0);
    check("reset row s", 32'(row_s), 32'd0);
    check("reset line_end s", 32'(line_end_s), 32'd0);
    check("reset frame_end s", 32'(frame_end_s), 32'd0);
    check("reset valid i", 32'(valid_i), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    start_frame(0, 3, 2);
    for (int l = 0; l < 6; l++) begin
      run_line(10, 2, 7, 2, 7, 0);
      gap(2);
    end
    end_frame(2);
    check("scn1 valid count strict", nv_s, 32'd8);
    check("scn1 valid count inclusive", nv_i, 32'd24);
    check_frame("scn1");
`ifdef CM_WINDOW_COUNTER_ERR_EN
    check("scn1 err strict", 32'(err_s), 32'd0);
    check("scn1 err inclusive", 32'(err_i), 32'd0);
`endif

    start_frame(0, 3, 1);
    run_line(10, 2, 7, 2, 7, 0);
    gap(2);
    run_line(10, 2, 7, 2, 9, 1);
    gap(2);
    run_line(10, 2, 9, 2, 9, 0);
    hsync = 1'b0;
    vsync = 1'b0;
    exp_fe++;
    tick();
    check("drop line_end strict", 32'(line_end_s), 32'd1);
    check("drop frame_end strict", 32'(frame_end_s), 32'd1);
    check("drop row strict", 32'(row_s), 32'd0);
    check("drop line_end inclusive", 32'(line_end_i), 32'd1);
    check("drop frame_end inclusive", 32'(frame_end_i), 32'd1);
    check("drop row inclusive", 32'(row_i), 32'd0);
    repeat (2) tick();
    check("scn3 valid count strict", nv_s, 32'd10);
    check("scn3 valid count inclusive", nv_i, 32'd20);
    check_frame("scn3");

    start_frame(0, 3, 1);
    run_line(10, 5, 6, 5, 6, 0);
`ifdef CM_WINDOW_COUNTER_ERR_EN
    check("degen err strict", 32'(err_s), 32'd1);
    check("degen err inclusive", 32'(err_i), 32'd0);
`endif
    gap(2);
    for (int l = 0; l < 3; l++) begin
      run_line(10, 5, 6, 5, 6, 0);
      gap(2);
    end
    end_frame(2);
    check("degen valid count strict", nv_s, 32'd0);
    check("degen valid count inclusive", nv_i, 32'd8);
    check_frame("degen");
`ifdef CM_WINDOW_COUNTER_ERR_EN
    check("degen err sticky", 32'(err_s), 32'd1);
`endif

    start_frame(0, 3, 1);
    run_line(10, 2, 7, 2, 7, 0);
    gap(2);
    chk_en = 1'b0;
    h_back = HW'(2); h_front = HW'(7); hsync = 1'b1;
    repeat (5) tick();
    check("pre-reset valid strict", 32'(valid_s), 32'd1);
    check("pre-reset col strict", 32'(col_s), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset valid strict", 32'(valid_s), 32'd0);
    check("mid reset col strict", 32'(col_s), 32'd0);
    check("mid reset row strict", 32'(row_s), 32'd0);
    check("mid reset valid inclusive", 32'(valid_i), 32'd0);
    check("mid reset row inclusive", 32'(row_i), 32'd0);
`ifdef CM_WINDOW_COUNTER_ERR_EN
    check("mid reset err strict", 32'(err_s), 32'd0);
`endif
    q_s.delete(); q_i.delete();
    nv_s = 0; nv_i = 0; nle_s = 0; nle_i = 0; nfe_s = 0; nfe_i = 0;
    exp_le = 0; exp_fe = 0;
    model_frame_begin(0, 3);
    chk_en = 1'b1;
    for (int l = 0; l < 3; l++) begin
      run_line(10, 2, 7, 2, 7, 0);
      gap(2);
    end
    end_frame(2);
    check("post-reset valid count strict", nv_s, 32'd8);
    check("post-reset valid count inclusive", nv_i, 32'd18);
    check_frame("post-reset");

    for (int f = 0; f < 8; f++) begin
      vb = int'($urandom_range(0, 3));
      vf = int'($urandom_range(0, 6));
      nl = int'($urandom_range(2, 6));
      start_frame(vb, vf, int'($urandom_range(1, 3)));
      for (int l = 0; l < nl; l++) begin
        len = int'($urandom_range(1, 16));
        hb  = int'($urandom_range(0, 10));
        hf  = int'($urandom_range(0, 14));
        chg = int'($urandom_range(0, 16));
        run_line(len, hb, hf, int'($urandom_range(0, 10)), int'($urandom_range(0, 14)), chg);
        if (l == 0) begin
          v_back  = VW'($urandom_range(0, 5));
          v_front = VW'($urandom_range(0, 7));
        end
        if (l < nl - 1 || $urandom_range(0, 1) == 0) gap(int'($urandom_range(1, 3)));
      end
      end_frame(2);
      check_frame("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cm_window_counter.md
Name: cm_window_counter

Overview:
- 2-D active-window position counter for the CM video path; parametrised successor of the single-axis porch counter.
- Counts sync-qualified cycles per line and lines per frame; asserts valid inside the programmed horizontal and vertical windows; outputs zero-based column/row.
- Adds per-line porch shadowing, selectable boundary mode and line/frame event pulses.
- Sits between sync generation and pixel-address logic.

Parameters:
- H_WIDTH, 11, width of horizontal porches, internal cycle counter and col.
- V_WIDTH, 10, width of vertical porches, internal line counter and row.
- INCLUSIVE, 0: 0 = window strictly between porches (back < n < front); 1 = back <= n <= front.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- h_back_porch  in  H_WIDTH  horizontal window lower bound, in cycles.
- h_front_porch  in  H_WIDTH  horizontal window upper bound, in cycles.
- v_back_porch  in  V_WIDTH  vertical window lower bound, in lines.
- v_front_porch  in  V_WIDTH  vertical window upper bound, in lines.
- hsync  in  1  line-active qualifier; high for the whole line.
- vsync  in  1  frame-active qualifier; high for the whole frame.
- valid  out  1  current col/row lie inside the 2-D window.
- col  out  H_WIDTH  zero-based column inside the window.
- row  out  V_WIDTH  zero-based row inside the window.
- line_end  out  1  one-cycle pulse when a line ends while vsync is high.
- frame_end  out  1  one-cycle pulse when vsync falls.

Behaviour:
- Reset (rst=1 at a clk edge): all registers and outputs are 0. The first rise of hsync or vsync after reset is detected relative to a previous value of 0.
- Registers: h_cnt, v_cnt, hsync_d, vsync_d, porch shadows, col, row, valid, line_end, frame_end.
- h_cnt:
  - hsync=0: clears to 0.
  - hsync=1: increments and saturates at all-ones; it does not wrap.
- h_in: h_cnt compared against the shadowed h porches using the INCLUSIVE rule.
- Porch shadowing:
  - h porches are loaded into shadows on the hsync rise (hsync=1, hsync_d=0).
  - v porches are loaded on the vsync rise.
  - Porch changes mid-line or mid-frame have no effect until the next rise.
  - On a rise cycle, compares use the newly loaded values; the shadow register is bypassed that cycle.
- Line end: hsync_d=1 and hsync=0.
- v_cnt:
  - vsync=0: clears to 0.
  - vsync=1: increments on each line end and saturates at all-ones.
- v_in: v_cnt compared against the shadowed v porches using the INCLUSIVE rule.
- Latency: outputs are registered, one cycle after the qualifying sample.
  - valid_nxt = hsync & vsync & h_in & v_in.
  - col: 0 on the first cycle of a valid run, then +1 per valid cycle. Cleared when valid_nxt=0.
  - row: 0 for the first line with v_in=1, then +1 on each line end while v_in. Cleared when vsync=0.
- line_end is registered from the line-end condition, gated by vsync.
- frame_end is registered from (vsync_d & ~vsync).
- Degenerate window (front <= back+1 strict, or front < back inclusive): valid never asserts; counters still run.
- hsync and vsync falling in the same cycle: both line_end and frame_end pulse; v_cnt and row clear.
- Reset mid-line: everything clears. A line already in progress (hsync high at reset release) is treated as starting at reset release.

Optional Feature:
- Macro: CM_WINDOW_COUNTER_ERR_EN.
- Defined:
  - Adds output port err (1 bit), sticky.
  - err is set when h_cnt or v_cnt saturates, or when a degenerate window is loaded into the shadows.
  - err is cleared only by rst.
- Undefined: no err port and no detection logic.

Decomposition:
- Shared package cm_pkg:
  - boundary-mode encodings (CM_WIN_STRICT=0, CM_WIN_INCLUSIVE=1);
  - default H_WIDTH/V_WIDTH constants.
- One sub-module, cm_axis_window (parameter WIDTH):
  - contains the saturating counter, porch shadow and in-window compare;
  - instantiated once for the horizontal axis and once for the vertical axis.
- Top level adds col/row generation and event pulses.

Test Plan:
- Default widths, strict mode; h porches 2/7, v porches 0/3, vsync high, 6 lines of 10 hsync-high cycles:
  - valid is high 4 cycles per line (h_cnt 3..6), col 0..3;
  - lines with v_cnt 1..2 are valid, row 0 then 1.
- Same stimulus with INCLUSIVE=1:
  - 6 cycles per line (h_cnt 2..7), col 0..5;
  - v_cnt 0..3 valid, rows 0..3.
- Change h_front_porch 7→9 mid-line: the current line still gives 4 valid cycles; the next line gives 6.
- h porches 5/6 in strict mode: valid never asserts across a full frame. With ERR_EN, err=1 after the hsync rise and stays set.
- Assert rst for 1 cycle mid-window: the next cycle has valid=0, col=0, row=0; a subsequent full line behaves as in scenario 1.
- Drop hsync and vsync together: line_end=1 and frame_end=1 in the same cycle; row and v_cnt return to 0.
